// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM states, operation mode
// and the carry-seed helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

  // Subtraction is A + ~B + 1, so the +1 comes in through the initial carry.
  function automatic logic carry_init(mode_t m);
    return (m == MODE_SUB);
  endfunction

endpackage

// File: rtl/serial_fa.sv
// Bit-serial full adder with a registered carry; on the first bit the carry is
// taken from cinit instead of the register.
module serial_fa (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic first,
  input  logic cinit,
  input  logic sub,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cin,
  output logic cout
);

  logic carry_reg;
  logic bx;

  assign bx   = b ^ sub;
  assign cin  = first ? cinit : carry_reg;
  assign sum  = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg <= 1'b0;
    end else if (en) begin
      carry_reg <= cout;
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: operands arrive LSB first, the WIDTH+1 bit result
// leaves MSB first. Optional overflow flag with SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic mode_i,
  input  logic ina,
  input  logic inb,
  output logic out,
  output logic en_o,
  output logic busy_o
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic ovf_o
`endif
);

  localparam int CW = $clog2(WIDTH + 2);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  mode_t          mode_reg;
  mode_t          mode_eff;
  logic [WIDTH-1:0] res_reg;
  logic           top_reg;
  logic           fa_en, fa_first, fa_sum, fa_cin, fa_cout;
  logic           last_bit;
  logic           send_done;

  // The first bit pair is consumed in IDLE, so mode_i applies directly there.
  assign mode_eff  = (state == IDLE) ? mode_t'(mode_i) : mode_reg;
  assign fa_first  = (state == IDLE);
  assign fa_en     = en_i && (state != SEND);
  assign last_bit  = (state == LOAD) && en_i && (cnt == CW'(WIDTH - 1));
  assign send_done = (state == SEND) && (cnt == CW'(WIDTH));

  serial_fa u_fa (
    .clk  (clk),
    .rst  (rst),
    .en   (fa_en),
    .first(fa_first),
    .cinit(carry_init(mode_eff)),
    .sub  (mode_eff == MODE_SUB),
    .a    (ina),
    .b    (inb),
    .sum  (fa_sum),
    .cin  (fa_cin),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en_i) state_next = LOAD;
      LOAD: begin
        if (!en_i) begin
          state_next = IDLE;
        end else if (last_bit) begin
          state_next = SEND;
        end
      end
      SEND: if (send_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // {top_reg, res_reg} doubles as the output shifter once loading is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mode_reg <= MODE_ADD;
      res_reg  <= '0;
      top_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i) begin
            cnt      <= CW'(1);
            mode_reg <= mode_t'(mode_i);
            res_reg  <= {fa_sum, res_reg[WIDTH-1:1]};
            top_reg  <= 1'b0;
          end
        end
        LOAD: begin
          if (!en_i) begin
            cnt     <= '0;
            res_reg <= '0;
            top_reg <= 1'b0;
          end else begin
            res_reg <= {fa_sum, res_reg[WIDTH-1:1]};
            if (last_bit) begin
              cnt     <= '0;
              top_reg <= (mode_reg == MODE_SUB) ? ~fa_cout : fa_cout;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        SEND: begin
          {top_reg, res_reg} <= {res_reg, 1'b0};
          cnt <= send_done ? '0 : cnt + CW'(1);
        end
        default: begin
          cnt     <= '0;
          res_reg <= '0;
          top_reg <= 1'b0;
        end
      endcase
    end
  end

  assign en_o   = (state == SEND);
  assign busy_o = (state != IDLE);
  assign out    = en_o ? top_reg : 1'b0;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_reg;

  // Two's-complement overflow: carry into the MSB differs from carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (last_bit) begin
      ovf_reg <= fa_cin ^ fa_cout;
    end else if (state != SEND) begin
      ovf_reg <= 1'b0;
    end
  end

  assign ovf_o = ovf_reg && en_o;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized scoreboard bench for serial_addsub (WIDTH = 4); checks ovf_o when
// built with SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub;

  localparam int W    = 4;
  localparam int MASK = (1 << (W + 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_i = 1'b0, mode_i = 1'b0, ina = 1'b0, inb = 1'b0;
  logic out, en_o, busy_o;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_o;
`endif

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en_i),
    .mode_i(mode_i),
    .ina   (ina),
    .inb   (inb),
    .out   (out),
    .en_o  (en_o),
    .busy_o(busy_o)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf_o (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   col_val = 0;
  int   col_len = 0;
  bit   ovf_and = 1'b1;
  bit   ovf_or  = 1'b0;

  function automatic int to_signed(int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic exp_t model(int a, int b, bit m);
    exp_t e;
    int   r;
    e.val = m ? ((a - b) & MASK) : ((a + b) & MASK);
    r = m ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
    e.ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: assembles each en_o run MSB first and compares it against the queue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        col_val = 0; col_len = 0; ovf_and = 1'b1; ovf_or = 1'b0;
      end else if (en_o) begin
        col_val = (col_val << 1) | int'(out);
        col_len++;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_and = ovf_and & ovf_o;
        ovf_or  = ovf_or | ovf_o;
`endif
        check("busy_during_send", int'(busy_o), 1);
      end else begin
        check("out_zero_when_idle", int'(out), 0);
        if (col_len > 0) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got %0d (%0d bits), expected no output", col_val, col_len);
          end else begin
            e = exp_q.pop_front();
            check("result_len", col_len, W + 1);
            check("result_val", col_val, e.val);
            $display("result %0d (%0d bits) expected %0d", col_val, col_len, e.val);
`ifdef SERIAL_ADDSUB_OVF_EN
            check("ovf_and", int'(ovf_and), int'(e.ovf));
            check("ovf_or", int'(ovf_or), int'(e.ovf));
`endif
          end
          col_val = 0; col_len = 0; ovf_and = 1'b1; ovf_or = 1'b0;
        end
      end
    end
  endtask

  task automatic drive_cycle(bit e, bit a, bit b, bit m);
    en_i = e; ina = a; inb = b; mode_i = m;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, bit m, int len);
    for (int i = 0; i < len; i++) begin
      drive_cycle(1'b1, a[i], b[i], (i == 0) ? m : 1'($urandom_range(0, 1)));
    end
    if (len == W) begin
      exp_q.push_back(model(int'(a), int'(b), m));
      check("en_o_latency", int'(en_o), 1);
    end
  endtask

  task automatic filler(bit random_en, bit force_en);
    for (int i = 0; i < W + 1; i++) begin
      drive_cycle(random_en ? 1'($urandom_range(0, 1)) : force_en,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    end
  endtask

  task automatic abort_op(logic [W-1:0] a, logic [W-1:0] b, bit m, int len);
    run_op(a, b, m, len);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("busy_after_abort", int'(busy_o), 0);
    check("en_o_after_abort", int'(en_o), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    #1 rst = 1'b1;
    #1;
    check("reset_out", int'(out), 0);
    check("reset_en_o", int'(en_o), 0);
    check("reset_busy", int'(busy_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Directed cases
    run_op(4'hB, 4'h6, 1'b0, W); filler(1'b0, 1'b0);
    run_op(4'h3, 4'h5, 1'b1, W); filler(1'b0, 1'b0);
    run_op(4'h5, 4'h3, 1'b1, W); filler(1'b0, 1'b0);
    abort_op(4'h7, 4'h7, 1'b0, 2);
    run_op(4'h1, 4'h1, 1'b0, W); filler(1'b0, 1'b0);
    run_op(4'h7, 4'h1, 1'b0, W); filler(1'b0, 1'b0);
    run_op(4'h2, 4'h1, 1'b0, W); filler(1'b0, 1'b0);
    run_op(4'h8, 4'h8, 1'b1, W); filler(1'b0, 1'b0);

    // Reset during the third SEND cycle
    run_op(4'hF, 4'hF, 1'b0, W);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midsend_rst_out", int'(out), 0);
    check("midsend_rst_en_o", int'(en_o), 0);
    check("midsend_rst_busy", int'(busy_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // en_i held high through SEND, then straight into the next operation
    run_op(4'h9, 4'h4, 1'b0, W);
    filler(1'b0, 1'b1);
    run_op(4'h6, 4'hA, 1'b1, W);
    filler(1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] a, b;
      bit m;
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        abort_op(a, b, m, $urandom_range(1, W - 1));
      end else begin
        run_op(a, b, m, W);
        filler(1'b1, 1'b0);
        for (int g = $urandom_range(0, 2); g > 0; g--) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("pending_expectations", exp_q.size(), 0);
    check("partial_output_run", col_len, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
